serial_word_rx: RTL
===================

Name: serial_word_rx

Overview:
- Downstream consumer of the serial shift chain.
- Takes the `sout` bit stream plus a bit-valid strobe and a start-of-frame marker, and assembles WIDTH-bit words MSB-first.
- Optionally checks one even-parity bit per word.
- Buffers completed words in a DEPTH-entry FIFO with a valid/ready output handshake, so the parallel consumer can stall without losing words.

Parameters:
- WIDTH, 8, data bits per word (≥2)
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- PARITY_EN, 1, 1 = one even-parity bit follows each word; 0 = no parity bit

Ports:
- clock  input  1  single clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- sin  input  1  serial data bit (driven by shift chain sout)
- sin_valid  input  1  sin is sampled only when high
- sof  input  1  qualified by sin_valid; marks current bit as first data bit of a word
- dout  output  WIDTH  FIFO head word
- dout_valid  output  1  FIFO non-empty
- dout_ready  input  1  consumer accepts head when dout_valid & dout_ready
- fifo_count  output  $clog2(DEPTH)+1  words held
- parity_err  output  1  one-cycle pulse on parity mismatch
- overflow  output  1  sticky: a completed word was dropped because FIFO full
- clear_ovf  input  1  synchronous clear of overflow

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE, bit counter=0, shift reg=0, FIFO empty. Outputs: dout=0, dout_valid=0, fifo_count=0, parity_err=0, overflow=0. Reset mid-word discards the partial word.
- Bit order: first data bit after sof lands in dout[WIDTH-1]; last data bit lands in dout[0].
- FSM states:
  - IDLE: sin_valid&sof loads bit as MSB, cnt=1 → DATA. sin_valid without sof is ignored.
  - DATA: each sin_valid shifts sin in and increments cnt. When cnt reaches WIDTH: go to PARITY if PARITY_EN, else complete the word and go to IDLE.
  - PARITY: on sin_valid, compare sin with XOR of data bits.
    - Equal: complete the word.
    - Differ: drop the word, parity_err=1 for the next cycle.
    - Either way → IDLE.
- sof&sin_valid in DATA or PARITY: abort the partial word silently (no error), load the bit as a new MSB, cnt=1, stay in or enter DATA.
- sin_valid=0 cycles: hold all state. Gaps are allowed anywhere in a word.
- Complete: push into the FIFO on the same edge the last bit (data or parity) is sampled. With FIFO empty and dout_ready=0, dout_valid=1 and dout=word in the cycle after that edge (latency 1).
- Pop: on an edge where dout_valid&dout_ready. dout/dout_valid reflect the new head the next cycle. dout is stable while dout_valid&!dout_ready.
- Push and pop on the same edge:
  - Count unchanged.
  - Allowed even when full; the push is accepted.
  - When empty, only the push happens.
- Full and push without pop: word dropped, overflow=1 from the next cycle.
- overflow stays 1 until clear_ovf=1 on a clock edge.
- If clear_ovf and a new drop coincide, set wins.
- FIFO pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.

Test Plan:
- Basic word, PARITY_EN=1, dout_ready=1: after reset, send sof + bits 1,0,1,1,0,0,1,0, then parity bit 0. Required: dout=8'hB2, dout_valid=1 for exactly one cycle (popped), parity_err=0.
- Parity error: same data with parity bit 1. Required: parity_err one-cycle pulse, dout_valid stays 0, fifo_count=0.
- Backpressure/overflow, DEPTH=4, dout_ready=0: send words 8'h01..8'h05 with correct parity. Required:
  - fifo_count=4, dout=8'h01, overflow=1.
  - Then dout_ready=1: dout sequence 01,02,03,04, then dout_valid=0.
  - clear_ovf → overflow=0.
- Abort/restart: sof, three bits 1,1,1, then sof + bits 0,1,0,1,0,1,0,1 + parity 0. Required: single word 8'h55, no parity_err.
- Gaps and simultaneous push/pop: sin_valid toggled 1,0,0,1,… across a word; FIFO full with dout_ready=1 exactly on a push edge. Required: word still correct; fifo_count stays 4, overflow stays 0.
- Reset mid-word: assert reset_n=0 after 5 bits, release, send a full word 8'hA5. Required: all outputs 0 during reset; only 8'hA5 emitted afterwards.

Source files
------------

// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver: MSB-first assembly with optional even parity,
// followed by a DEPTH-entry FIFO with a valid/ready output handshake.
module serial_word_rx #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     sin,
  input  logic                     sin_valid,
  input  logic                     sof,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     parity_err,
  output logic                     overflow,
  input  logic                     clear_ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               parity_err_q, parity_err_d;

  logic               push;
  logic [WIDTH-1:0]   push_word;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               overflow_q, overflow_d;

  logic               full;
  logic               pop;
  logic               wr_en;
  logic               drop;

  // Word assembly FSM: next state, shift/count update and completion strobe
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    parity_err_d = 1'b0;
    push         = 1'b0;
    push_word    = '0;

    if (sin_valid) begin
      if (sof) begin
        // A start marker always restarts, silently discarding any partial word
        state_d = ST_DATA;
        cnt_d   = CNT_W'(1);
        shift_d = WIDTH'(sin);
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_d = ST_IDLE;
          end
          ST_DATA: begin
            shift_d = {shift_q[WIDTH-2:0], sin};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              if (PARITY_EN) begin
                state_d = ST_PARITY;
              end else begin
                push      = 1'b1;
                push_word = {shift_q[WIDTH-2:0], sin};
                state_d   = ST_IDLE;
                cnt_d     = '0;
              end
            end
          end
          ST_PARITY: begin
            if (sin == (^shift_q)) begin
              push      = 1'b1;
              push_word = shift_q;
            end else begin
              parity_err_d = 1'b1;
            end
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  // FIFO control; the head word is precomputed so dout leaves a register
  always_comb begin
    full  = (count_q == CW'(DEPTH));
    pop   = dout_valid_q & dout_ready;
    wr_en = push & (~full | pop);
    drop  = push & full & ~pop;

    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    dout_valid_d = (count_d != '0);
    if (count_d == '0) begin
      dout_d = '0;
    end else if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
      dout_d = push_word;
    end else begin
      dout_d = mem_q[rd_ptr_d];
    end

    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      parity_err_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      parity_err_q <= parity_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign fifo_count = count_q;
  assign parity_err = parity_err_q;
  assign overflow   = overflow_q;

endmodule
